mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 28 ++
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between a requester and the mem_responder block.
//
// Handshake: the requester presents exactly one of Rd/Wr with Addr/DataIn.
// The responder samples the request only on a rising edge where Stall=0.
// Once it has taken a request it holds Stall=1 until the transaction ends,
// and it ignores every input change in that time. Done pulses for one cycle
// with DataOut valid. Stall never depends combinationally on Rd, Wr or Addr.
// A malformed request pulses err for one cycle and is otherwise dropped.
interface mem_responder_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        err;

  modport master (
    output Addr, DataIn, Rd, Wr,
    input  DataOut, Done, Stall, err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr,
    output DataOut, Done, Stall, err
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency 16-bit word memory responder.
// A legal request in IDLE is latched, counted down in BUSY and completed
// with a one-cycle Done pulse in RESP. Writes commit on the BUSY->RESP edge.
// The whole array sits in flops so that reset can clear every word.
module mem_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus,
  output logic [1:0]      state_dbg_o
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CNT_W = 4;
  // BUSY lasts LATENCY-1 cycles, so counting LATENCY-2 down to 0 lands the
  // RESP cycle exactly LATENCY cycles after the accepting edge.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [15:0]            wdata_q, wdata_d;
  logic                   is_wr_q, is_wr_d;
  logic [15:0]            dout_q, dout_d;
  logic                   err_q, err_d;
  logic                   mem_we;
  logic [15:0]            mem_q [DEPTH];

  logic                   req_legal;
  logic                   req_illegal;

  // Upper address bits do not select anything; addresses alias.
  logic                   unused_addr;
  assign unused_addr = &{1'b0, bus.Addr[15:ADDR_BITS+1]};

  // Request classification: one op only, and the byte address must be even.
  assign req_legal   = (bus.Rd ^ bus.Wr) & ~bus.Addr[0];
  assign req_illegal = (bus.Rd | bus.Wr) & ~req_legal;

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    dout_d  = 16'h0000;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_legal) begin
          idx_d   = bus.Addr[ADDR_BITS:1];
          wdata_d = bus.DataIn;
          is_wr_d = bus.Wr;
          cnt_d   = CNT_LOAD;
          state_d = S_BUSY;
        end else if (req_illegal) begin
          err_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          mem_we  = is_wr_q;
          // The read samples the array before any commit on this edge.
          dout_d  = is_wr_q ? 16'h0000 : mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and transaction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= 16'h0000;
      is_wr_q <= 1'b0;
      dout_q  <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // Storage array; reset clears every word, so a write aborted by reset is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  // Outputs decode from registered state only.
  assign bus.Done    = (state_q == S_RESP);
  assign bus.Stall   = (state_q != S_IDLE);
  assign bus.DataOut = dout_q;
  assign bus.err     = err_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: vector table of single transactions,
// back-to-back held request, and reset abort sequence.
module tb_mem_responder;

  localparam int LAT = 4;
  localparam int AB  = 8;

  // Clock and reset
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  mem_responder_if bus();

  mem_responder #(.LATENCY(LAT), .ADDR_BITS(AB)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // Scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        exp_err;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs for one cycle; on Done pop the expected read data.
  task automatic check_cycle(input string tag, input logic exp_done,
                             input logic exp_stall, input logic exp_err);
    logic [15:0] e;
    check({tag, ".Done"},  {15'b0, bus.Done},  {15'b0, exp_done});
    check({tag, ".Stall"}, {15'b0, bus.Stall}, {15'b0, exp_stall});
    check({tag, ".err"},   {15'b0, bus.err},   {15'b0, exp_err});
    if (!exp_done) begin
      check({tag, ".DataOut_idle"}, bus.DataOut, 16'h0000);
    end else if (exp_q.size() == 0) begin
      check({tag, ".exp_q_empty"}, 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".DataOut"}, bus.DataOut, e);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] din);
    bus.Rd     = rd;
    bus.Wr     = wr;
    bus.Addr   = addr;
    bus.DataIn = din;
  endtask

  task automatic scramble();
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
  endtask

  // One request from IDLE through completion (or err pulse) back to IDLE.
  task automatic run_req(input vec_t v, input int id);
    drive(v.rd, v.wr, v.addr, v.din);
    if (!v.exp_err) exp_q.push_back(v.exp_dout);
    @(posedge clk); #1;
    if (!v.exp_err) begin
      for (int k = 1; k <= LAT; k++) begin
        scramble();
        @(negedge clk);
        check_cycle($sformatf("v%0d_c%0d", id, k), k == LAT, 1'b1, 1'b0);
        @(posedge clk); #1;
      end
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      check_cycle($sformatf("v%0d_idle", id), 1'b0, 1'b0, 1'b0);
    end else begin
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      check_cycle($sformatf("v%0d_errpulse", id), 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check_cycle($sformatf("v%0d_errclear", id), 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] rnd;
    vec_t        v;

    vecs[0]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0020, 16'h1111, 1'b0, 16'hBEEF};
    vecs[3]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 16'h0004, 16'h5555, 1'b1, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 16'h0002, 16'hA5A5, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 16'h0202, 16'h0000, 1'b0, 16'hA5A5};
    vecs[7]  = '{1'b0, 1'b1, 16'hFFFE, 16'h1234, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 16'h01FE, 16'h0000, 1'b0, 16'h1234};
    vecs[9]  = '{1'b0, 1'b1, 16'h0003, 16'hDEAD, 1'b1, 16'h0000};
    vecs[10] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'hA5A5};
    vecs[11] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};

    // Reset state
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cycle("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Vector table; the first request is driven right as reset releases
    for (int i = 0; i < 12; i++) begin
      run_req(vecs[i], i);
    end

    // Rd held high with Addr churning: only IDLE-cycle addresses count
    drive(1'b1, 1'b0, 16'h0020, 16'h0000);
    exp_q.push_back(16'hBEEF);
    @(posedge clk); #1;
    for (int k = 1; k <= 2 * LAT + 2; k++) begin
      if (k == LAT + 1) begin
        drive(1'b1, 1'b0, 16'h0002, 16'h0000);
        exp_q.push_back(16'hA5A5);
      end else if (k == 2 * LAT + 2) begin
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      end else begin
        rnd = 15'($urandom_range(0, 32767));
        drive(1'b1, 1'b0, {rnd, 1'b0}, 16'($urandom_range(0, 65535)));
      end
      @(negedge clk);
      check_cycle($sformatf("b2b_c%0d", k), (k == LAT) || (k == 2 * LAT + 1),
                  !((k == LAT + 1) || (k == 2 * LAT + 2)), 1'b0);
      @(posedge clk); #1;
    end

    // Reset in the middle of a write
    drive(1'b0, 1'b1, 16'h0040, 16'h1234);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check_cycle("rst_pre", 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_cycle("rst_mid", 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      check_cycle($sformatf("rst_nodone_%0d", k), 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    v = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000};
    run_req(v, 100);
    v = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000};
    run_req(v, 101);

    check("exp_q_drained", 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
